if_id_buffer: RTL and testbench

//   Two-entry elastic pipeline register between the IF stage and ID. Captures the
//   {nextPC, instruction} pair produced by IF and presents it to decode with a

---
 rtl/if_id_buffer_pkg.sv | 11 +
 rtl/if_id_buffer_sat_counter.sv | 33 +++
 rtl/if_id_buffer.sv | 112 +++++++++++
 tb/tb_if_id_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID elastic buffer: state encodings and the
// NOP word that decode also treats as a bubble.
package if_id_buffer_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_buffer_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clear wins.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry elastic register between fetch and decode: head entry plus one
// skid slot so fetch may run one beat ahead of a stalled decode.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD,
  parameter int                CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] nextPC_in,
  input  logic [DATA_W-1:0] instruction_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] nextPC_out,
  output logic [DATA_W-1:0] instruction_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] head_pc_q, head_pc_d;
  logic [DATA_W-1:0] head_instr_q, head_instr_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic              push, pop;

  // Handshake outputs depend on state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (FLUSH) begin
      // Fetch refetches from the branch target, so the beat in flight is dropped.
      if (state_q != ST_EMPTY) begin
        state_d      = ST_EMPTY;
        head_pc_d    = '0;
        head_instr_d = NOP_INSTR;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d      = ST_ONE;
            head_pc_d    = nextPC_in;
            head_instr_d = instruction_in;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_pc_d    = nextPC_in;
            head_instr_d = instruction_in;
          end else if (push) begin
            state_d      = ST_TWO;
            skid_pc_d    = nextPC_in;
            skid_instr_d = instruction_in;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d      = ST_ONE;
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_EMPTY;
      head_pc_q    <= '0;
      head_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign nextPC_out      = head_pc_q;
  assign instruction_out = out_valid ? head_instr_q : NOP_INSTR;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (out_valid & ~out_ready & ~FLUSH),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer built with a 4-bit stall counter.
module tb_if_id_buffer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] instr_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] instr_out;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  if_id_buffer #(
    .DATA_W    (DATA_W),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK             (clk),
    .RST             (rst),
    .FLUSH           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .nextPC_in       (pc_in),
    .instruction_in  (instr_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .nextPC_out      (pc_out),
    .instruction_out (instr_out),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir,
                         input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    chk({tag, " instruction_out"}, instr_out, ins);
    chk({tag, " nextPC_out"}, pc_out, pc);
    chk({tag, " stall_cnt"}, {28'd0, stall_cnt}, cnt);
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic iv, input logic ordy, input logic fl,
                      input logic [31:0] pc, input logic [31:0] ins);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    pc_in     = pc;
    instr_in  = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_to_negedge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; pc_in = '0; instr_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //         iv  rdy fl  pc      ins      | ov  ir  ins      pc      cnt
    vecs[0]  = '{1, 1, 0, 32'h01, 32'hA1,  1, 1, 32'hA1, 32'h01, 0};
    vecs[1]  = '{1, 1, 0, 32'h02, 32'hA2,  1, 1, 32'hA2, 32'h02, 0};
    vecs[2]  = '{1, 1, 0, 32'h03, 32'hA3,  1, 1, 32'hA3, 32'h03, 0};
    vecs[3]  = '{0, 1, 0, 32'h00, 32'h00,  0, 1, 32'h00, 32'h03, 0};
    vecs[4]  = '{1, 0, 0, 32'h11, 32'hB1,  1, 1, 32'hB1, 32'h11, 0};
    vecs[5]  = '{1, 0, 0, 32'h12, 32'hB2,  1, 0, 32'hB1, 32'h11, 1};
    vecs[6]  = '{1, 0, 0, 32'h19, 32'hB9,  1, 0, 32'hB1, 32'h11, 2};
    vecs[7]  = '{0, 1, 0, 32'h00, 32'h00,  1, 1, 32'hB2, 32'h12, 2};
    vecs[8]  = '{0, 1, 0, 32'h00, 32'h00,  0, 1, 32'h00, 32'h12, 2};
    vecs[9]  = '{1, 0, 0, 32'h21, 32'hC1,  1, 1, 32'hC1, 32'h21, 2};
    vecs[10] = '{1, 0, 0, 32'h22, 32'hC2,  1, 0, 32'hC1, 32'h21, 3};
    vecs[11] = '{1, 0, 1, 32'h23, 32'hC3,  0, 1, 32'h00, 32'h00, 3};
    vecs[12] = '{0, 1, 0, 32'h00, 32'h00,  0, 1, 32'h00, 32'h00, 3};
    vecs[13] = '{1, 1, 0, 32'h31, 32'hE1,  1, 1, 32'hE1, 32'h31, 3};
    vecs[14] = '{1, 1, 1, 32'h32, 32'hE2,  0, 1, 32'h00, 32'h00, 3};
    vecs[15] = '{1, 1, 0, 32'h33, 32'hE3,  1, 1, 32'hE3, 32'h33, 3};
    vecs[16] = '{0, 1, 0, 32'h00, 32'h00,  0, 1, 32'h00, 32'h33, 3};
    vecs[17] = '{0, 0, 1, 32'h00, 32'h00,  0, 1, 32'h00, 32'h33, 3};

    do_reset();
    chk_all("reset", 1'b0, 1'b1, 32'h0, 32'h0, 32'd0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc, vecs[i].ins);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
              vecs[i].e_ins, vecs[i].e_pc, vecs[i].e_cnt);
      idle_to_negedge();
    end

    // Saturation: a single stuck head for 2^CNT_W+5 cycles.
    do_reset();
    step(1, 0, 0, 32'h51, 32'hF1);
    chk_all("sat push", 1'b1, 1'b1, 32'hF1, 32'h51, 32'd0);
    idle_to_negedge();
    begin
      int exp_cnt;
      exp_cnt = 0;
      for (int k = 0; k < (1 << CNT_W) + 5; k++) begin
        step(0, 0, 0, 32'h0, 32'h0);
        if (exp_cnt < 15) exp_cnt++;
        chk($sformatf("sat cyc%0d stall_cnt", k), {28'd0, stall_cnt}, exp_cnt);
        idle_to_negedge();
      end
    end
    chk("sat final", {28'd0, stall_cnt}, 32'h0000_000F);

    // Asynchronous reset while full: outputs clear before the next edge.
    do_reset();
    step(1, 0, 0, 32'h61, 32'hC1);
    idle_to_negedge();
    step(1, 0, 0, 32'h62, 32'hC2);
    chk_all("full", 1'b1, 1'b0, 32'hC1, 32'h61, 32'd1);
    idle_to_negedge();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("async rst", 1'b0, 1'b1, 32'h0, 32'h0, 32'd0);
    @(posedge clk);
    #1;
    chk_all("rst held", 1'b0, 1'b1, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 32'h41, 32'hD1);
    chk_all("post rst D1", 1'b1, 1'b1, 32'hD1, 32'h41, 32'd0);
    idle_to_negedge();
    step(1, 1, 0, 32'h42, 32'hD2);
    chk_all("post rst D2", 1'b1, 1'b1, 32'hD2, 32'h42, 32'd0);
    idle_to_negedge();
    step(0, 1, 0, 32'h0, 32'h0);
    chk_all("post rst drain", 1'b0, 1'b1, 32'h0, 32'h42, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
